// File: rtl/rs_if.sv
// Bundle of decoder dispatch, result broadcast and issue signals for the reservation station.
// The master side is the decoder/broadcast/EX environment; the slave side is the RS itself.
interface rs_if #(
  parameter int OP_W  = 5,
  parameter int DAT_W = 32,
  parameter int ROB_W = 4
);
  logic             iDec_En;
  logic [OP_W-1:0]  iDec_Op;
  logic [DAT_W-1:0] iDec_Pc;
  logic [DAT_W-1:0] iDec_Imm;
  logic             iDec_Rj;
  logic [DAT_W-1:0] iDec_Vj;
  logic [ROB_W-1:0] iDec_Qj;
  logic             iDec_Rk;
  logic [DAT_W-1:0] iDec_Vk;
  logic [ROB_W-1:0] iDec_Qk;
  logic [ROB_W-1:0] iDec_Qd;
  logic             oDec_Full;

  logic             iEX_En;
  logic [ROB_W-1:0] iEX_Qd;
  logic [DAT_W-1:0] iEX_Vd;
  logic             iLSB_En;
  logic [ROB_W-1:0] iLSB_Qd;
  logic [DAT_W-1:0] iLSB_Vd;

  logic             oEX_En;
  logic [OP_W-1:0]  oEX_Op;
  logic [DAT_W-1:0] oEX_Pc;
  logic [DAT_W-1:0] oEX_Imm;
  logic [DAT_W-1:0] oEX_Vs1;
  logic [DAT_W-1:0] oEX_Vs2;
  logic [ROB_W-1:0] oEX_Qd;

  modport master (
    output iDec_En, iDec_Op, iDec_Pc, iDec_Imm, iDec_Rj, iDec_Vj, iDec_Qj,
           iDec_Rk, iDec_Vk, iDec_Qk, iDec_Qd,
           iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
    input  oDec_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
  );

  modport slave (
    input  iDec_En, iDec_Op, iDec_Pc, iDec_Imm, iDec_Rj, iDec_Vj, iDec_Qj,
           iDec_Rk, iDec_Vk, iDec_Qk, iDec_Qd,
           iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
    output oDec_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
  );
endinterface

// File: rtl/rs.sv
// Reservation station for the ALU/branch path: buffers dispatched ops, wakes operands from the
// EX/LSB broadcast buses and issues the lowest-index ready entry, one per cycle, to EX.
module rs #(
  parameter int RS_SIZE = 16,
  parameter int OP_W    = 5,
  parameter int DAT_W   = 32,
  parameter int ROB_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  rs_if.slave  bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]            r_busy, r_rj, r_rk;
  logic [RS_SIZE-1:0][OP_W-1:0]  r_op;
  logic [RS_SIZE-1:0][DAT_W-1:0] r_pc, r_imm, r_vj, r_vk;
  logic [RS_SIZE-1:0][ROB_W-1:0] r_qj, r_qk, r_qd;

  logic [RS_SIZE-1:0]            w_busyN, w_rjN, w_rkN;
  logic [RS_SIZE-1:0][OP_W-1:0]  w_opN;
  logic [RS_SIZE-1:0][DAT_W-1:0] w_pcN, w_immN, w_vjN, w_vkN;
  logic [RS_SIZE-1:0][ROB_W-1:0] w_qjN, w_qkN, w_qdN;

  logic             r_exEn;
  logic [OP_W-1:0]  r_exOp;
  logic [DAT_W-1:0] r_exPc, r_exImm, r_exVs1, r_exVs2;
  logic [ROB_W-1:0] r_exQd;

  logic             w_exEnN;
  logic [OP_W-1:0]  w_exOpN;
  logic [DAT_W-1:0] w_exPcN, w_exImmN, w_exVs1N, w_exVs2N;
  logic [ROB_W-1:0] w_exQdN;

  logic             w_issueValid, w_freeValid, w_full;
  logic [IDX_W-1:0] w_issueIdx, w_freeIdx;
  logic             w_dispRj, w_dispRk;
  logic [DAT_W-1:0] w_dispVj, w_dispVk;

  // Both selects scan downwards so the last hit is the lowest index.
  always_comb begin
    w_issueValid = 1'b0;
    w_issueIdx   = '0;
    w_freeValid  = 1'b0;
    w_freeIdx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (r_busy[i] && r_rj[i] && r_rk[i]) begin
        w_issueValid = 1'b1;
        w_issueIdx   = IDX_W'(i);
      end
      if (!r_busy[i]) begin
        w_freeValid = 1'b1;
        w_freeIdx   = IDX_W'(i);
      end
    end
  end

  assign w_full        = &r_busy;
  assign bus.oDec_Full = w_full;

  // Same-cycle forwarding for the op being dispatched; EX wins over LSB.
  always_comb begin
    w_dispRj = bus.iDec_Rj;
    w_dispVj = bus.iDec_Vj;
    if (!bus.iDec_Rj) begin
      if (bus.iEX_En && bus.iEX_Qd == bus.iDec_Qj) begin
        w_dispRj = 1'b1;
        w_dispVj = bus.iEX_Vd;
      end else if (bus.iLSB_En && bus.iLSB_Qd == bus.iDec_Qj) begin
        w_dispRj = 1'b1;
        w_dispVj = bus.iLSB_Vd;
      end
    end
    w_dispRk = bus.iDec_Rk;
    w_dispVk = bus.iDec_Vk;
    if (!bus.iDec_Rk) begin
      if (bus.iEX_En && bus.iEX_Qd == bus.iDec_Qk) begin
        w_dispRk = 1'b1;
        w_dispVk = bus.iEX_Vd;
      end else if (bus.iLSB_En && bus.iLSB_Qd == bus.iDec_Qk) begin
        w_dispRk = 1'b1;
        w_dispVk = bus.iLSB_Vd;
      end
    end
  end

  always_comb begin
    w_busyN = r_busy;
    w_rjN   = r_rj;
    w_rkN   = r_rk;
    w_opN   = r_op;
    w_pcN   = r_pc;
    w_immN  = r_imm;
    w_vjN   = r_vj;
    w_vkN   = r_vk;
    w_qjN   = r_qj;
    w_qkN   = r_qk;
    w_qdN   = r_qd;
    w_exEnN  = 1'b0;
    w_exOpN  = '0;
    w_exPcN  = '0;
    w_exImmN = '0;
    w_exVs1N = '0;
    w_exVs2N = '0;
    w_exQdN  = '0;
    if (clr) begin
      w_busyN = '0;
    end else begin
      if (w_issueValid) begin
        w_busyN[w_issueIdx] = 1'b0;
        w_exEnN  = 1'b1;
        w_exOpN  = r_op[w_issueIdx];
        w_exPcN  = r_pc[w_issueIdx];
        w_exImmN = r_imm[w_issueIdx];
        w_exVs1N = r_vj[w_issueIdx];
        w_exVs2N = r_vk[w_issueIdx];
        w_exQdN  = r_qd[w_issueIdx];
      end
      // Wakeup only touches flags sampled at cycle start, so nothing woken here issues this cycle.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_rj[i]) begin
          if (bus.iEX_En && bus.iEX_Qd == r_qj[i]) begin
            w_rjN[i] = 1'b1;
            w_vjN[i] = bus.iEX_Vd;
          end else if (bus.iLSB_En && bus.iLSB_Qd == r_qj[i]) begin
            w_rjN[i] = 1'b1;
            w_vjN[i] = bus.iLSB_Vd;
          end
        end
        if (r_busy[i] && !r_rk[i]) begin
          if (bus.iEX_En && bus.iEX_Qd == r_qk[i]) begin
            w_rkN[i] = 1'b1;
            w_vkN[i] = bus.iEX_Vd;
          end else if (bus.iLSB_En && bus.iLSB_Qd == r_qk[i]) begin
            w_rkN[i] = 1'b1;
            w_vkN[i] = bus.iLSB_Vd;
          end
        end
      end
      if (bus.iDec_En && !w_full && w_freeValid) begin
        w_busyN[w_freeIdx] = 1'b1;
        w_opN[w_freeIdx]   = bus.iDec_Op;
        w_pcN[w_freeIdx]   = bus.iDec_Pc;
        w_immN[w_freeIdx]  = bus.iDec_Imm;
        w_rjN[w_freeIdx]   = w_dispRj;
        w_vjN[w_freeIdx]   = w_dispVj;
        w_qjN[w_freeIdx]   = bus.iDec_Qj;
        w_rkN[w_freeIdx]   = w_dispRk;
        w_vkN[w_freeIdx]   = w_dispVk;
        w_qkN[w_freeIdx]   = bus.iDec_Qk;
        w_qdN[w_freeIdx]   = bus.iDec_Qd;
      end
    end
  end

  // Only busy flags and the issue port are reset; payload fields are don't-care while not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_exEn  <= 1'b0;
      r_exOp  <= '0;
      r_exPc  <= '0;
      r_exImm <= '0;
      r_exVs1 <= '0;
      r_exVs2 <= '0;
      r_exQd  <= '0;
    end else if (en) begin
      r_busy  <= w_busyN;
      r_rj    <= w_rjN;
      r_rk    <= w_rkN;
      r_op    <= w_opN;
      r_pc    <= w_pcN;
      r_imm   <= w_immN;
      r_vj    <= w_vjN;
      r_vk    <= w_vkN;
      r_qj    <= w_qjN;
      r_qk    <= w_qkN;
      r_qd    <= w_qdN;
      r_exEn  <= w_exEnN;
      r_exOp  <= w_exOpN;
      r_exPc  <= w_exPcN;
      r_exImm <= w_exImmN;
      r_exVs1 <= w_exVs1N;
      r_exVs2 <= w_exVs2N;
      r_exQd  <= w_exQdN;
    end
  end

  assign bus.oEX_En  = r_exEn;
  assign bus.oEX_Op  = r_exOp;
  assign bus.oEX_Pc  = r_exPc;
  assign bus.oEX_Imm = r_exImm;
  assign bus.oEX_Vs1 = r_exVs1;
  assign bus.oEX_Vs2 = r_exVs2;
  assign bus.oEX_Qd  = r_exQd;
endmodule

// File: tb/tb_rs.sv
// Directed bench for rs: a per-cycle vector table for dispatch/wakeup/forwarding, then
// hand-written fill/order, flush and enable-hold sequences.
module tb_rs;
  logic clk = 1'b0;
  logic rst, en, clr;
  int   nCompared = 0;
  int   nMismatched = 0;

  rs_if #(.OP_W(5), .DAT_W(32), .ROB_W(4)) bus ();

  rs #(.RS_SIZE(16), .OP_W(5), .DAT_W(32), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dEn;
    logic [4:0]  op;
    logic [31:0] pc, imm;
    logic        rj;
    logic [31:0] vj;
    logic [3:0]  qj;
    logic        rk;
    logic [31:0] vk;
    logic [3:0]  qk, qd;
    logic        exEn;
    logic [3:0]  exQd;
    logic [31:0] exVd;
    logic        lsbEn;
    logic [3:0]  lsbQd;
    logic [31:0] lsbVd;
    logic        eEn;
    logic [4:0]  eOp;
    logic [31:0] ePc, eImm, eVs1, eVs2;
    logic [3:0]  eQd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t dsp(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                               input logic rj, input logic [31:0] vj, input logic [3:0] qj,
                               input logic rk, input logic [31:0] vk, input logic [3:0] qk,
                               input logic [3:0] qd);
    vec_t v;
    v = '0;
    v.dEn = 1'b1; v.op = op; v.pc = pc; v.imm = imm;
    v.rj = rj; v.vj = vj; v.qj = qj; v.rk = rk; v.vk = vk; v.qk = qk; v.qd = qd;
    return v;
  endfunction

  function automatic vec_t bc(input vec_t vin, input logic exEn, input logic [3:0] exQd,
                              input logic [31:0] exVd, input logic lsbEn, input logic [3:0] lsbQd,
                              input logic [31:0] lsbVd);
    vec_t v;
    v = vin;
    v.exEn = exEn; v.exQd = exQd; v.exVd = exVd;
    v.lsbEn = lsbEn; v.lsbQd = lsbQd; v.lsbVd = lsbVd;
    return v;
  endfunction

  function automatic vec_t xp(input vec_t vin, input logic [4:0] op, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] vs1, input logic [31:0] vs2,
                              input logic [3:0] qd);
    vec_t v;
    v = vin;
    v.eEn = 1'b1; v.eOp = op; v.ePc = pc; v.eImm = imm; v.eVs1 = vs1; v.eVs2 = vs2; v.eQd = qd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iDec_En  = v.dEn;  bus.iDec_Op = v.op;  bus.iDec_Pc = v.pc;  bus.iDec_Imm = v.imm;
    bus.iDec_Rj  = v.rj;   bus.iDec_Vj = v.vj;  bus.iDec_Qj = v.qj;
    bus.iDec_Rk  = v.rk;   bus.iDec_Vk = v.vk;  bus.iDec_Qk = v.qk;  bus.iDec_Qd = v.qd;
    bus.iEX_En   = v.exEn;  bus.iEX_Qd = v.exQd;  bus.iEX_Vd = v.exVd;
    bus.iLSB_En  = v.lsbEn; bus.iLSB_Qd = v.lsbQd; bus.iLSB_Vd = v.lsbVd;
  endtask

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    cmpVal({name, ".en"},  32'(bus.oEX_En),  32'(v.eEn));
    cmpVal({name, ".op"},  32'(bus.oEX_Op),  32'(v.eOp));
    cmpVal({name, ".pc"},  bus.oEX_Pc,       v.ePc);
    cmpVal({name, ".imm"}, bus.oEX_Imm,      v.eImm);
    cmpVal({name, ".vs1"}, bus.oEX_Vs1,      v.eVs1);
    cmpVal({name, ".vs2"}, bus.oEX_Vs2,      v.eVs2);
    cmpVal({name, ".qd"},  32'(bus.oEX_Qd),  32'(v.eQd));
  endtask

  initial begin
    vec_t v;
    // Per-cycle table: inputs held across one edge, expected issue port just after it.
    vecs.push_back(dsp(5'h0B, 32'h100, 32'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 4'd2));
    vecs.push_back(xp(nop(), 5'h0B, 32'h100, 32'd3, 32'd5, 32'd0, 4'd2));
    vecs.push_back(nop());
    vecs.push_back(dsp(5'h01, 32'h104, 32'd0, 1'b0, 32'd0, 4'd7, 1'b1, 32'd10, 4'd0, 4'd3));
    vecs.push_back(bc(nop(), 1'b1, 4'd6, 32'd99, 1'b0, 4'd0, 32'd0));
    vecs.push_back(bc(nop(), 1'b1, 4'd7, 32'd32, 1'b0, 4'd0, 32'd0));
    vecs.push_back(xp(nop(), 5'h01, 32'h104, 32'd0, 32'd32, 32'd10, 4'd3));
    vecs.push_back(bc(dsp(5'h02, 32'h108, 32'd0, 1'b0, 32'd0, 4'd4, 1'b1, 32'd1, 4'd0, 4'd5),
                      1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hABCD));
    vecs.push_back(xp(nop(), 5'h02, 32'h108, 32'd0, 32'hABCD, 32'd1, 4'd5));
    vecs.push_back(dsp(5'h03, 32'h10C, 32'd0, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd9, 4'd7));
    vecs.push_back(bc(nop(), 1'b1, 4'd6, 32'h11, 1'b1, 4'd9, 32'h22));
    vecs.push_back(xp(nop(), 5'h03, 32'h10C, 32'd0, 32'h11, 32'h22, 4'd7));
    vecs.push_back(dsp(5'h04, 32'h110, 32'd0, 1'b0, 32'd0, 4'd8, 1'b0, 32'd0, 4'd8, 4'd8));
    vecs.push_back(bc(nop(), 1'b1, 4'd8, 32'hAA, 1'b1, 4'd8, 32'hBB));
    vecs.push_back(xp(nop(), 5'h04, 32'h110, 32'd0, 32'hAA, 32'hAA, 4'd8));
    vecs.push_back(dsp(5'h05, 32'h120, 32'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd9));
    vecs.push_back(xp(dsp(5'h06, 32'h124, 32'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd10),
                      5'h05, 32'h120, 32'd0, 32'd1, 32'd2, 4'd9));
    vecs.push_back(xp(nop(), 5'h06, 32'h124, 32'd0, 32'd3, 32'd4, 4'd10));
    vecs.push_back(nop());

    rst = 1'b1; en = 1'b1; clr = 1'b0;
    applyStimulus(nop());
    tick();
    tick();
    checkOutput("reset", nop());
    cmpVal("reset.full", 32'(bus.oDec_Full), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Fill all 16 entries waiting on tag 15, try one more dispatch, then wake them all at once.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(dsp(5'(i), 32'h200 + 32'(4 * i), 32'(i), 1'b0, 32'd0, 4'd15,
                        1'b1, 32'(100 + i), 4'd0, 4'(i)));
      tick();
      cmpVal($sformatf("fill%0d.en", i), 32'(bus.oEX_En), 32'd0);
      cmpVal($sformatf("fill%0d.full", i), 32'(bus.oDec_Full), (i == 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(dsp(5'h1F, 32'hDEAD, 32'd0, 1'b1, 32'hDEAD, 4'd0, 1'b1, 32'd0, 4'd0, 4'd0));
    tick();
    cmpVal("fullDrop.en", 32'(bus.oEX_En), 32'd0);
    cmpVal("fullDrop.full", 32'(bus.oDec_Full), 32'd1);
    applyStimulus(bc(nop(), 1'b1, 4'd15, 32'h77, 1'b0, 4'd0, 32'd0));
    tick();
    cmpVal("wakeAll.en", 32'(bus.oEX_En), 32'd0);
    applyStimulus(nop());
    for (int i = 0; i < 16; i++) begin
      tick();
      v = xp(nop(), 5'(i), 32'h200 + 32'(4 * i), 32'(i), 32'h77, 32'(100 + i), 4'(i));
      checkOutput($sformatf("order%0d", i), v);
      cmpVal($sformatf("order%0d.full", i), 32'(bus.oDec_Full), 32'd0);
    end
    tick();
    checkOutput("afterOrder", nop());

    // Flush with three waiting entries while their producer broadcasts.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(dsp(5'h0A, 32'(i), 32'd0, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 4'(i)));
      tick();
    end
    clr = 1'b1;
    applyStimulus(bc(dsp(5'h0C, 32'h400, 32'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd13),
                     1'b1, 4'd12, 32'd5, 1'b0, 4'd0, 32'd0));
    tick();
    clr = 1'b0;
    checkOutput("flush", nop());
    cmpVal("flush.full", 32'(bus.oDec_Full), 32'd0);
    applyStimulus(bc(nop(), 1'b1, 4'd12, 32'd5, 1'b0, 4'd0, 32'd0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("postFlush%0d", i), nop());
      applyStimulus(nop());
    end

    // Enable low freezes an in-flight issue and ignores dispatch.
    applyStimulus(dsp(5'h07, 32'h300, 32'd1, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20, 4'd0, 4'd1));
    tick();
    applyStimulus(dsp(5'h08, 32'h304, 32'd2, 1'b1, 32'h30, 4'd0, 1'b1, 32'h40, 4'd0, 4'd2));
    tick();
    v = xp(nop(), 5'h07, 32'h300, 32'd1, 32'h10, 32'h20, 4'd1);
    checkOutput("issueA", v);
    en = 1'b0;
    applyStimulus(dsp(5'h09, 32'h308, 32'd3, 1'b1, 32'h50, 4'd0, 1'b1, 32'h60, 4'd0, 4'd3));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hold%0d", i), v);
    end
    en = 1'b1;
    applyStimulus(nop());
    tick();
    checkOutput("issueB", xp(nop(), 5'h08, 32'h304, 32'd2, 32'h30, 32'h40, 4'd2));
    tick();
    checkOutput("noC", nop());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
